// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access sequencer.
package dmem_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 32;

    // req_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane logic: extracts and extends sub-word loads, merges
// sub-word store data into a full RAM word.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, sign/zero extension and store merge
    always_comb begin
        byte_sel   = word[{addr_lo, 3'b000} +: 8];
        half_sel   = word[{addr_lo[1], 4'b0000} +: 16];
        load_val   = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_val   = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val   = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
                store_word = word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_val   = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencer between the MEM stage and a word-only data RAM. Sub-word stores
// run as read-modify-write; loads are lane-extracted and extended.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [31:0]       ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t state, state_nxt;

    logic [31:0]       a_addr;
    logic [1:0]        a_size;
    logic              a_uns;
    logic              a_we;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] wbuf;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              req_bad;
    logic [31:0]       lane_word;
    logic [31:0]       load_val;
    logic [31:0]       store_word;

    assign accept = req_valid && (state == ST_IDLE);

    // Request validity: misaligned half/word, reserved size, or beyond RAM
    always_comb begin
        req_bad = 1'b0;
        if (req_size == SZ_RSVD)                                  req_bad = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])                   req_bad = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)        req_bad = 1'b1;
        if ({1'b0, req_addr} >= ADDR_LIMIT)                       req_bad = 1'b1;
    end

    // RD extracts from the live RAM word; WR merges into the buffered word
    assign lane_word = (state == ST_RD) ? ram_rdata : wbuf;

    dmem_lane_unit u_lane (
        .word        (lane_word),
        .addr_lo     (a_addr[1:0]),
        .size        (a_size),
        .is_unsigned (a_uns),
        .wdata       (a_wdata),
        .load_val    (load_val),
        .store_word  (store_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)                                  state_nxt = ST_RESP;
                    else if (!req_we || req_size != SZ_WORD)      state_nxt = ST_RD;
                    else                                          state_nxt = ST_WR;
                end
            end
            ST_RD:   state_nxt = a_we ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs; RAM strobes are also gated by rst so a reset during WR
    // cannot let the falling-edge RAM write go through
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        ram_re     = (state == ST_RD) && !rst;
        ram_we     = (state == ST_WR) && !rst;
    end

    // Request latches, word buffer and response data register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr  <= '0;
            a_size  <= '0;
            a_uns   <= 1'b0;
            a_we    <= 1'b0;
            a_wdata <= '0;
            wbuf    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_addr  <= req_addr;
                        a_size  <= req_size;
                        a_uns   <= req_unsigned;
                        a_we    <= req_we;
                        a_wdata <= req_wdata;
                        err_q   <= req_bad;
                        if (req_bad) rdata_q <= '0;
                    end
                end
                ST_RD: begin
                    wbuf <= ram_rdata;
                    if (!a_we) rdata_q <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign ram_addr   = {a_addr[31:2], 2'b00};
    assign ram_wdata  = store_word;

endmodule
